cpu_mc_control_fsm: RTL and testbench
=====================================

# cpu_mc_control_fsm

Parametrised multicycle control FSM for the RV32I CPU core. It sequences fetch, decode, execute, memory and writeback by driving every datapath select and write enable. It adds three things: wait-state handshaking on the memory port, an optional RV32M multiply/divide unit (MDU) handshake, and illegal-instruction trapping. It sits between the instruction register and the datapath muxes of the CPU core.

## Interface
- MEM_WAIT_EN, 1, 1: memory states hold until mem_ready. 0: mem_ready is ignored and treated as 1.
- MEXT_EN, 0, 1: R-type with funct7=0000001 is routed to the MDU. 0: that encoding is illegal.
- TRAP_EN, 1, 1: illegal encodings enter TRAP. 0: illegal encodings return to FETCH with no side effects.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- opc  in  7  instruction opcode from the instruction register
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- z_flag  in  1  ALU result-zero flag (combinational, current cycle)
- mem_ready  in  1  memory access completes this cycle
- mdu_done  in  1  MDU result valid (single-cycle pulse)
- pc_wr_en  out  1  PC register write
- mem_addr_src  out  1  0=PC, 1=ALU-out register
- mem_rd_en  out  1  memory read request
- mem_wr_en  out  1  memory write
- instr_wr_en  out  1  instruction/old-PC register write
- result_src  out  2  0=ALU-out register, 1=memory data, 2=ALU result, 3=MDU result
- alu_op_sel  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
- alu_a_src  out  2  0=PC, 1=old PC, 2=rs1, 3=zero
- alu_b_src  out  2  0=rs2, 1=immediate, 2=constant 4
- imd_src  out  3  0 I, 1 S, 2 B, 3 U, 4 J
- regfl_wr_en  out  1  register file write
- mdu_start  out  1  one-cycle MDU start pulse
- trap  out  1  illegal instruction; held until reset

## Operation
- Unlisted outputs are 0 in every state. The state register is 4 bits.
- **FETCH:** mem_rd_en=1, alu_a=0, alu_b=2, ADD, result_src=2.
  - instr_wr_en and pc_wr_en are both set to mem_ready; advance to DECODE on mem_ready.
- **DECODE:** alu_a=1, alu_b=1, ADD.
  - imd_src=J when opc=1101111, otherwise B.
  - Next state by opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R, or MDU when MEXT_EN and funct7=0000001
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → illegal
- **MEM_ADDR:** alu_a=2, alu_b=1, ADD. imd_src=I for loads (→MEM_RD), S for stores (→MEM_WR).
- **MEM_RD:** mem_addr_src=1, mem_rd_en=1. Advance to MEM_WB on mem_ready.
- **MEM_WB:** result_src=1, regfl_wr_en=1, then FETCH.
- **MEM_WR:** mem_addr_src=1, mem_wr_en=1. Held until mem_ready, then FETCH.
- **EXEC_R:** alu_a=2, alu_b=0, then ALU_WB. ALU op from funct3:
  - 000: ADD, or SUB if funct7[5]
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101: SRL, or SRA if funct7[5]
  - 110 OR, 111 AND
  - Any funct7 other than 0000000/0100000 (or 0000001 when MEXT_EN) is illegal.
- **EXEC_I:** alu_a=2, alu_b=1, imd_src=I, then ALU_WB. Same op map as EXEC_R, except funct3=000 is always ADD; funct7[5] only selects SRA when funct3=101.
- **ALU_WB:** result_src=0, regfl_wr_en=1, then FETCH.
- **BRANCH:** alu_a=2, alu_b=0, result_src=0, then FETCH.
  - Op: SUB for funct3 0xx, SLT for 10x, SLTU for 11x.
  - pc_wr_en=taken, where taken = z_flag for 000/101/111 and !z_flag for 001/100/110.
  - funct3 010 or 011 is illegal.
- **JAL:** result_src=0, pc_wr_en=1, then LINK.
- **JALR:** alu_a=2, alu_b=1, imd_src=I, ADD, result_src=2, pc_wr_en=1, then LINK.
- **LINK:** alu_a=1, alu_b=2, ADD, result_src=2, regfl_wr_en=1, then FETCH.
- **LUI:** alu_a=3, alu_b=1, imd_src=U, ADD, then ALU_WB.
- **AUIPC:** alu_a=1, alu_b=1, imd_src=U, ADD, then ALU_WB.
- **MDU:** mdu_start=1 on the first cycle in the state only (tracked by a registered first-cycle flag).
  - On mdu_done: result_src=3, regfl_wr_en=1, then FETCH.
  - mdu_done arriving in the start cycle is accepted.
- **Illegal:** go to TRAP when TRAP_EN, otherwise to FETCH.
- **TRAP:** trap=1, no other enables; terminal until rst.

## Timing
- Reset: state=FETCH and the first-cycle flag is cleared asynchronously.
  - While rst=1, pc_wr_en, instr_wr_en, mem_rd_en, mem_wr_en, regfl_wr_en, mdu_start and trap are forced to 0.
  - All selects show their FETCH values during reset.
  - Reset mid-instruction abandons the instruction with no further writes.
- Outputs are combinational from state, gated by mem_ready, mdu_done and z_flag in the same cycle. The state updates on the rising edge.
- Cycles per instruction with zero wait states:
  - load 5
  - store, R, I, JAL, JALR, LUI, AUIPC 4
  - branch 3
  - MDU 3 + MDU latency
- Each cycle with mem_ready=0 adds one cycle in FETCH, MEM_RD or MEM_WR. All other outputs stay stable while stalled.

## Test plan
- Reset: assert rst mid-MEM_WR with mem_wr_en=1 → mem_wr_en drops immediately; after release, FETCH with mem_rd_en=1 and pc_wr_en=0 until mem_ready.
- Load with mem_ready low for 2 cycles in FETCH and in MEM_RD → 9 cycles total, regfl_wr_en=1 exactly once with result_src=1.
- BNE (funct3=001):
  - z_flag=0 → pc_wr_en=1 in BRANCH.
  - z_flag=1 → pc_wr_en=0.
  - BLTU → alu_op_sel=6.
- JALR → cycle 3 pc_wr_en=1 with result_src=2; cycle 4 regfl_wr_en=1 with alu_a=1, alu_b=2.
- MEXT_EN=1, MUL (funct7=0000001), mdu_done after 5 cycles → mdu_start high for exactly 1 cycle, then regfl_wr_en=1 with result_src=3.
- Illegal opcode 1111111:
  - TRAP_EN=1 → trap=1 held across 10 cycles, no enables.
  - TRAP_EN=0 → back to FETCH, no writes.

Source files
------------

// File: rtl/cpu_mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// with memory wait states, optional RV32M handoff and illegal-instruction trapping.
module cpu_mc_control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit MEXT_EN     = 1'b0,
    parameter bit TRAP_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opc,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       z_flag,
    input  logic       mem_ready,
    input  logic       mdu_done,
    output logic       pc_wr_en,
    output logic       mem_addr_src,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic       instr_wr_en,
    output logic [1:0] result_src,
    output logic [3:0] alu_op_sel,
    output logic [1:0] alu_a_src,
    output logic [1:0] alu_b_src,
    output logic [2:0] imd_src,
    output logic       regfl_wr_en,
    output logic       mdu_start,
    output logic       trap
);

    // LUI and AUIPC share one state (UPPER) so the full state set fits in 4 bits.
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR,
        S_LINK, S_UPPER, S_MDU, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL  = 4'd8, ALU_SRA = 4'd9;

    localparam state_t S_ILLEGAL = TRAP_EN ? S_TRAP : S_FETCH;

    state_t state_q, state_d;
    logic   first_q, first_d;
    logic   ready;
    logic   r_is_mdu, r_is_base, taken;

    assign ready     = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign r_is_base = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    assign r_is_mdu  = MEXT_EN && (funct7 == 7'b0000001);

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Equality branches compare via SUB, ordered ones via SLT/SLTU; zero flag picks the sense.
    always_comb begin
        case (funct3)
            3'b000, 3'b101, 3'b111: taken = z_flag;
            3'b001, 3'b100, 3'b110: taken = !z_flag;
            default:                taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_wr_en     = 1'b0;
        mem_addr_src = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        instr_wr_en  = 1'b0;
        result_src   = 2'd0;
        alu_op_sel   = ALU_ADD;
        alu_a_src    = 2'd0;
        alu_b_src    = 2'd0;
        imd_src      = 3'd0;
        regfl_wr_en  = 1'b0;
        mdu_start    = 1'b0;
        trap         = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_rd_en   = 1'b1;
                alu_b_src   = 2'd2;
                result_src  = 2'd2;
                instr_wr_en = ready;
                pc_wr_en    = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_a_src = 2'd1;
                alu_b_src = 2'd1;
                imd_src   = (opc == OP_JAL) ? 3'd4 : 3'd2;
                case (opc)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R: begin
                        if (r_is_mdu)       state_d = S_MDU;
                        else if (r_is_base) state_d = S_EXEC_R;
                        else                state_d = S_ILLEGAL;
                    end
                    OP_I:      state_d = S_EXEC_I;
                    OP_BRANCH: state_d = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI, OP_AUIPC: state_d = S_UPPER;
                    default:   state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_a_src = 2'd2;
                alu_b_src = 2'd1;
                imd_src   = opc[5] ? 3'd1 : 3'd0;
                state_d   = opc[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_addr_src = 1'b1;
                mem_rd_en    = 1'b1;
                if (ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src  = 2'd1;
                regfl_wr_en = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_addr_src = 1'b1;
                mem_wr_en    = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_a_src  = 2'd2;
                alu_op_sel = alu_decode(funct3, funct7[5], 1'b1);
                state_d    = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_a_src  = 2'd2;
                alu_b_src  = 2'd1;
                alu_op_sel = alu_decode(funct3, funct7[5], 1'b0);
                state_d    = S_ALU_WB;
            end
            S_ALU_WB: begin
                regfl_wr_en = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_a_src  = 2'd2;
                alu_op_sel = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
                pc_wr_en   = taken;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                pc_wr_en = 1'b1;
                state_d  = S_LINK;
            end
            S_JALR: begin
                alu_a_src  = 2'd2;
                alu_b_src  = 2'd1;
                result_src = 2'd2;
                pc_wr_en   = 1'b1;
                state_d    = S_LINK;
            end
            S_LINK: begin
                alu_a_src   = 2'd1;
                alu_b_src   = 2'd2;
                result_src  = 2'd2;
                regfl_wr_en = 1'b1;
                state_d     = S_FETCH;
            end
            S_UPPER: begin
                alu_a_src = opc[5] ? 2'd3 : 2'd1;
                alu_b_src = 2'd1;
                imd_src   = 3'd3;
                state_d   = S_ALU_WB;
            end
            S_MDU: begin
                mdu_start = first_q;
                if (mdu_done) begin
                    result_src  = 2'd3;
                    regfl_wr_en = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_TRAP: trap = 1'b1;
            default: state_d = S_FETCH;
        endcase

        first_d = (state_d == S_MDU) && (state_q != S_MDU);

        // State is already FETCH asynchronously in reset; only enables need masking.
        if (rst) begin
            pc_wr_en    = 1'b0;
            instr_wr_en = 1'b0;
            mem_rd_en   = 1'b0;
            mem_wr_en   = 1'b0;
            regfl_wr_en = 1'b0;
            mdu_start   = 1'b0;
            trap        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_cpu_mc_control_fsm.sv
// Directed bench for cpu_mc_control_fsm: one DUT with MDU+trap enabled, one with
// wait states, MDU and trap all disabled; outputs are compared as packed control words.
module tb_cpu_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opc = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       z_flag = 1'b0, mem_ready = 1'b0, mdu_done = 1'b0;

    logic       a_pc, a_mas, a_rd, a_wr, a_iw, a_rf, a_ms, a_tr;
    logic [1:0] a_rs, a_as, a_bs;
    logic [3:0] a_op;
    logic [2:0] a_imd;
    logic       b_pc, b_mas, b_rd, b_wr, b_iw, b_rf, b_ms, b_tr;
    logic [1:0] b_rs, b_as, b_bs;
    logic [3:0] b_op;
    logic [2:0] b_imd;

    int tests = 0, failed = 0, rf_count = 0, ms_count = 0;

    always #5 clk = ~clk;

    cpu_mc_control_fsm #(.MEM_WAIT_EN(1'b1), .MEXT_EN(1'b1), .TRAP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opc(opc), .funct3(funct3), .funct7(funct7),
        .z_flag(z_flag), .mem_ready(mem_ready), .mdu_done(mdu_done),
        .pc_wr_en(a_pc), .mem_addr_src(a_mas), .mem_rd_en(a_rd), .mem_wr_en(a_wr),
        .instr_wr_en(a_iw), .result_src(a_rs), .alu_op_sel(a_op), .alu_a_src(a_as),
        .alu_b_src(a_bs), .imd_src(a_imd), .regfl_wr_en(a_rf), .mdu_start(a_ms), .trap(a_tr)
    );

    cpu_mc_control_fsm #(.MEM_WAIT_EN(1'b0), .MEXT_EN(1'b0), .TRAP_EN(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .opc(opc), .funct3(funct3), .funct7(funct7),
        .z_flag(z_flag), .mem_ready(mem_ready), .mdu_done(mdu_done),
        .pc_wr_en(b_pc), .mem_addr_src(b_mas), .mem_rd_en(b_rd), .mem_wr_en(b_wr),
        .instr_wr_en(b_iw), .result_src(b_rs), .alu_op_sel(b_op), .alu_a_src(b_as),
        .alu_b_src(b_bs), .imd_src(b_imd), .regfl_wr_en(b_rf), .mdu_start(b_ms), .trap(b_tr)
    );

    wire [20:0] obs1 = {a_pc, a_mas, a_rd, a_wr, a_iw, a_rs, a_op, a_as, a_bs, a_imd, a_rf, a_ms, a_tr};
    wire [20:0] obs2 = {b_pc, b_mas, b_rd, b_wr, b_iw, b_rs, b_op, b_as, b_bs, b_imd, b_rf, b_ms, b_tr};

    function automatic logic [20:0] ctl(input logic pc, mas, rd, wr, iw, input logic [1:0] rs,
                                        input logic [3:0] op, input logic [1:0] a, b,
                                        input logic [2:0] imd, input logic rf, ms, tr);
        return {pc, mas, rd, wr, iw, rs, op, a, b, imd, rf, ms, tr};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        opc    = o;
        funct3 = f3;
        funct7 = f7;
    endtask

    // Drive per-cycle handshakes, check mid-cycle, then advance to just after the next edge.
    task automatic runCycle(input string tag, input bit sel2, input logic rdy, input logic done,
                            input logic z, input logic [20:0] exp);
        mem_ready = rdy;
        mdu_done  = done;
        z_flag    = z;
        #1;
        checkOutput(tag, {11'd0, sel2 ? obs2 : obs1}, {11'd0, exp});
        if (obs1[2]) rf_count++;
        if (obs1[1]) ms_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        mem_ready = 1'b1;
        mdu_done = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_outputs", {11'd0, obs1}, {11'd0, ctl(0,0,0,0,0,2,0,0,2,0,0,0,0)});
        rst = 1'b0;
        mdu_done = 1'b0;
    endtask

    logic [20:0] E_F, E_FS, E_RST, E_D, E_DJ, E_MAL, E_MAS, E_MRD, E_MWB, E_MWR, E_AWB;
    logic [20:0] E_LINK, E_JALR, E_JAL, E_TRAP, E_MDUS, E_MDUD, E_MDUSD;

    initial begin
        E_F    = ctl(1,0,1,0,1,2,0,0,2,0,0,0,0);
        E_FS   = ctl(0,0,1,0,0,2,0,0,2,0,0,0,0);
        E_RST  = ctl(0,0,0,0,0,2,0,0,2,0,0,0,0);
        E_D    = ctl(0,0,0,0,0,0,0,1,1,2,0,0,0);
        E_DJ   = ctl(0,0,0,0,0,0,0,1,1,4,0,0,0);
        E_MAL  = ctl(0,0,0,0,0,0,0,2,1,0,0,0,0);
        E_MAS  = ctl(0,0,0,0,0,0,0,2,1,1,0,0,0);
        E_MRD  = ctl(0,1,1,0,0,0,0,0,0,0,0,0,0);
        E_MWB  = ctl(0,0,0,0,0,1,0,0,0,0,1,0,0);
        E_MWR  = ctl(0,1,0,1,0,0,0,0,0,0,0,0,0);
        E_AWB  = ctl(0,0,0,0,0,0,0,0,0,0,1,0,0);
        E_LINK = ctl(0,0,0,0,0,2,0,1,2,0,1,0,0);
        E_JALR = ctl(1,0,0,0,0,2,0,2,1,0,0,0,0);
        E_JAL  = ctl(1,0,0,0,0,0,0,0,0,0,0,0,0);
        E_TRAP = ctl(0,0,0,0,0,0,0,0,0,0,0,0,1);
        E_MDUS = ctl(0,0,0,0,0,0,0,0,0,0,0,1,0);
        E_MDUD = ctl(0,0,0,0,0,3,0,0,0,0,1,0,0);
        E_MDUSD = ctl(0,0,0,0,0,3,0,0,0,0,1,1,0);

        // Reset asserted in the middle of a stalled store.
        doReset();
        applyStimulus(7'b0100011, 3'b010, 7'd0);
        runCycle("st_fetch", 0, 1, 0, 0, E_F);
        runCycle("st_decode", 0, 1, 0, 0, E_D);
        runCycle("st_addr", 0, 1, 0, 0, E_MAS);
        mem_ready = 1'b0;
        #1;
        checkOutput("st_wr_stall", {11'd0, obs1}, {11'd0, E_MWR});
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_wr", {11'd0, obs1}, {11'd0, E_RST});
        @(posedge clk);
        #1;
        rst = 1'b0;
        runCycle("post_rst_stall0", 0, 0, 0, 0, E_FS);
        runCycle("post_rst_stall1", 0, 0, 0, 0, E_FS);
        runCycle("post_rst_fetch", 0, 1, 0, 0, E_F);
        runCycle("st2_decode", 0, 1, 0, 0, E_D);
        runCycle("st2_addr", 0, 1, 0, 0, E_MAS);
        runCycle("st2_wr", 0, 1, 0, 0, E_MWR);
        runCycle("st2_next_fetch", 0, 1, 0, 0, E_F);

        // Load with two wait states in FETCH and in MEM_RD: 9 cycles total.
        doReset();
        applyStimulus(7'b0000011, 3'b010, 7'd0);
        rf_count = 0;
        runCycle("ld_fetch_w0", 0, 0, 0, 0, E_FS);
        runCycle("ld_fetch_w1", 0, 0, 0, 0, E_FS);
        runCycle("ld_fetch", 0, 1, 0, 0, E_F);
        runCycle("ld_decode", 0, 1, 0, 0, E_D);
        runCycle("ld_addr", 0, 1, 0, 0, E_MAL);
        runCycle("ld_rd_w0", 0, 0, 0, 0, E_MRD);
        runCycle("ld_rd_w1", 0, 0, 0, 0, E_MRD);
        runCycle("ld_rd", 0, 1, 0, 0, E_MRD);
        runCycle("ld_wb", 0, 1, 0, 0, E_MWB);
        checkOutput("ld_regfl_writes", rf_count, 1);
        runCycle("ld_next_fetch", 0, 1, 0, 0, E_F);

        // Branches: BNE taken/not taken, BLTU taken, BGE taken.
        doReset();
        applyStimulus(7'b1100011, 3'b001, 7'd0);
        runCycle("bne_fetch", 0, 1, 0, 0, E_F);
        runCycle("bne_decode", 0, 1, 0, 0, E_D);
        runCycle("bne_taken", 0, 1, 0, 0, ctl(1,0,0,0,0,0,1,2,0,0,0,0,0));
        runCycle("bne2_fetch", 0, 1, 0, 1, E_F);
        runCycle("bne2_decode", 0, 1, 0, 1, E_D);
        runCycle("bne_not_taken", 0, 1, 0, 1, ctl(0,0,0,0,0,0,1,2,0,0,0,0,0));
        applyStimulus(7'b1100011, 3'b110, 7'd0);
        runCycle("bltu_fetch", 0, 1, 0, 0, E_F);
        runCycle("bltu_decode", 0, 1, 0, 0, E_D);
        runCycle("bltu_branch", 0, 1, 0, 0, ctl(1,0,0,0,0,0,6,2,0,0,0,0,0));
        applyStimulus(7'b1100011, 3'b101, 7'd0);
        runCycle("bge_fetch", 0, 1, 0, 1, E_F);
        runCycle("bge_decode", 0, 1, 0, 1, E_D);
        runCycle("bge_branch", 0, 1, 0, 1, ctl(1,0,0,0,0,0,5,2,0,0,0,0,0));

        // Jumps.
        applyStimulus(7'b1100111, 3'b000, 7'd0);
        runCycle("jalr_fetch", 0, 1, 0, 0, E_F);
        runCycle("jalr_decode", 0, 1, 0, 0, E_D);
        runCycle("jalr_exec", 0, 1, 0, 0, E_JALR);
        runCycle("jalr_link", 0, 1, 0, 0, E_LINK);
        applyStimulus(7'b1101111, 3'b000, 7'd0);
        runCycle("jal_fetch", 0, 1, 0, 0, E_F);
        runCycle("jal_decode", 0, 1, 0, 0, E_DJ);
        runCycle("jal_exec", 0, 1, 0, 0, E_JAL);
        runCycle("jal_link", 0, 1, 0, 0, E_LINK);

        // ALU ops, immediates and upper-immediate forms.
        applyStimulus(7'b0110011, 3'b000, 7'b0100000);
        runCycle("sub_fetch", 0, 1, 0, 0, E_F);
        runCycle("sub_decode", 0, 1, 0, 0, E_D);
        runCycle("sub_exec", 0, 1, 0, 0, ctl(0,0,0,0,0,0,1,2,0,0,0,0,0));
        runCycle("sub_wb", 0, 1, 0, 0, E_AWB);
        applyStimulus(7'b0110011, 3'b101, 7'b0100000);
        runCycle("sra_fetch", 0, 1, 0, 0, E_F);
        runCycle("sra_decode", 0, 1, 0, 0, E_D);
        runCycle("sra_exec", 0, 1, 0, 0, ctl(0,0,0,0,0,0,9,2,0,0,0,0,0));
        runCycle("sra_wb", 0, 1, 0, 0, E_AWB);
        applyStimulus(7'b0010011, 3'b000, 7'b0100000);
        runCycle("addi_fetch", 0, 1, 0, 0, E_F);
        runCycle("addi_decode", 0, 1, 0, 0, E_D);
        runCycle("addi_exec", 0, 1, 0, 0, ctl(0,0,0,0,0,0,0,2,1,0,0,0,0));
        runCycle("addi_wb", 0, 1, 0, 0, E_AWB);
        applyStimulus(7'b0010011, 3'b011, 7'd0);
        runCycle("sltiu_fetch", 0, 1, 0, 0, E_F);
        runCycle("sltiu_decode", 0, 1, 0, 0, E_D);
        runCycle("sltiu_exec", 0, 1, 0, 0, ctl(0,0,0,0,0,0,6,2,1,0,0,0,0));
        runCycle("sltiu_wb", 0, 1, 0, 0, E_AWB);
        applyStimulus(7'b0110111, 3'b000, 7'd0);
        runCycle("lui_fetch", 0, 1, 0, 0, E_F);
        runCycle("lui_decode", 0, 1, 0, 0, E_D);
        runCycle("lui_exec", 0, 1, 0, 0, ctl(0,0,0,0,0,0,0,3,1,3,0,0,0));
        runCycle("lui_wb", 0, 1, 0, 0, E_AWB);
        applyStimulus(7'b0010111, 3'b000, 7'd0);
        runCycle("auipc_fetch", 0, 1, 0, 0, E_F);
        runCycle("auipc_decode", 0, 1, 0, 0, E_D);
        runCycle("auipc_exec", 0, 1, 0, 0, ctl(0,0,0,0,0,0,0,1,1,3,0,0,0));
        runCycle("auipc_wb", 0, 1, 0, 0, E_AWB);

        // MUL with done after 5 cycles, then MUL with done in the start cycle.
        applyStimulus(7'b0110011, 3'b000, 7'b0000001);
        ms_count = 0;
        runCycle("mul_fetch", 0, 1, 0, 0, E_F);
        runCycle("mul_decode", 0, 1, 0, 0, E_D);
        runCycle("mul_start", 0, 1, 0, 0, E_MDUS);
        for (int i = 0; i < 3; i++) runCycle($sformatf("mul_wait%0d", i), 0, 1, 0, 0, 21'd0);
        runCycle("mul_done", 0, 1, 1, 0, E_MDUD);
        checkOutput("mul_start_pulses", ms_count, 1);
        runCycle("mul_next_fetch", 0, 1, 0, 0, E_F);
        runCycle("mul2_decode", 0, 1, 0, 0, E_D);
        runCycle("mul2_start_done", 0, 1, 1, 0, E_MDUSD);
        runCycle("mul2_next_fetch", 0, 1, 0, 0, E_F);

        // Illegal opcode traps and holds; bad funct7 and branch funct3 also trap.
        doReset();
        applyStimulus(7'b1111111, 3'b000, 7'd0);
        runCycle("ill_fetch", 0, 1, 0, 0, E_F);
        runCycle("ill_decode", 0, 1, 0, 0, E_D);
        for (int i = 0; i < 10; i++) runCycle($sformatf("trap_hold%0d", i), 0, 1, 1, 1, E_TRAP);
        doReset();
        applyStimulus(7'b0110011, 3'b000, 7'b0000010);
        runCycle("badf7_fetch", 0, 1, 0, 0, E_F);
        runCycle("badf7_decode", 0, 1, 0, 0, E_D);
        runCycle("badf7_trap", 0, 1, 0, 0, E_TRAP);
        doReset();
        applyStimulus(7'b1100011, 3'b011, 7'd0);
        runCycle("badbr_fetch", 0, 1, 0, 0, E_F);
        runCycle("badbr_decode", 0, 1, 0, 0, E_D);
        runCycle("badbr_trap", 0, 1, 0, 0, E_TRAP);

        // Second DUT: mem_ready ignored, illegal and MUL encodings fall back to FETCH.
        doReset();
        applyStimulus(7'b1111111, 3'b000, 7'd0);
        runCycle("nt_fetch_noready", 1, 0, 0, 0, E_F);
        runCycle("nt_ill_decode", 1, 0, 0, 0, E_D);
        runCycle("nt_ill_refetch", 1, 0, 0, 0, E_F);
        applyStimulus(7'b0110011, 3'b000, 7'b0000001);
        runCycle("nt_mul_decode", 1, 0, 1, 0, E_D);
        runCycle("nt_mul_refetch", 1, 0, 1, 0, E_F);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
